// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding,
// byte-lane mask constants and the write-mask alignment check.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } dmem_state_e;

   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   // Bytes may sit on any lane, halves on lanes 0/2, words only on lane 0.
   function automatic bit dmem_mask_legal(input logic [1:0] a, input logic [3:0] we);
      logic [3:0] sh_b;
      logic [3:0] sh_h;
      bit         ok;
      sh_b = MASK_B << a;
      sh_h = MASK_H << a;
      ok   = 1'b0;
      if (we == sh_b)
         ok = 1'b1;
      if ((we == sh_h) && (a[0] == 1'b0))
         ok = 1'b1;
      if ((we == MASK_W) && (a == 2'd0))
         ok = 1'b1;
      return ok;
   endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// DEPTH_WORDS x 32 storage with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module dmem_responder_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic          clk,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we_i[b])
            mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, byte-lane
// access, registered response. Optional counters: define DMEM_RESPONDER_STATS_EN.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2,
   parameter int CNT_W       = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_we,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
`ifdef DMEM_RESPONDER_STATS_EN
   output logic [CNT_W-1:0] rd_cnt,
   output logic [CNT_W-1:0] wr_cnt,
   output logic [CNT_W-1:0] err_cnt,
`endif
   output dmem_state_e dbg_state_o
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   // Handshakes: a request transfers on an edge where req_valid && req_ready, a
   // response on an edge where rsp_valid && rsp_ready; payloads are held until then.
   dmem_state_e state_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   addr_q;
   logic [3:0]    we_q;
   logic [31:0]   wdata_q;
   logic          req_ready_q;
   logic          rsp_valid_q;
   logic [31:0]   rsp_rdata_q;
   logic          rsp_err_q;

   logic          in_range;
   logic          is_read;
   logic          legal;
   logic [3:0]    arr_we;
   logic [AW-1:0] arr_raddr;
   logic [31:0]   arr_rdata;

   always_comb begin
      in_range  = ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));
      is_read   = (we_q == 4'b0000);
      legal     = in_range && (is_read || dmem_mask_legal(addr_q[1:0], we_q));
      arr_we    = ((state_q == ACCESS) && legal) ? we_q : 4'b0000;
      // Point the read port at the incoming address while idle so that a
      // zero-wait access already has the word on its registered output.
      arr_raddr = (state_q == IDLE) ? req_addr[AW+1:2] : addr_q[AW+1:2];
   end

   dmem_responder_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_array (
      .clk    (clk),
      .we_i   (arr_we),
      .waddr_i(addr_q[AW+1:2]),
      .wdata_i(wdata_q),
      .raddr_i(arr_raddr),
      .rdata_o(arr_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         we_q        <= '0;
         wdata_q     <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               req_ready_q <= 1'b1;
               if (req_valid && req_ready_q) begin
                  addr_q      <= req_addr;
                  we_q        <= req_we;
                  wdata_q     <= req_wdata;
                  cnt_q       <= CW'(WAIT_CYCLES);
                  req_ready_q <= 1'b0;
                  state_q     <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1))
                  state_q <= ACCESS;
            end
            ACCESS: begin
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= !legal;
               rsp_rdata_q <= (legal && is_read) ? arr_rdata : 32'h0;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign dbg_state_o = state_q;

`ifdef DMEM_RESPONDER_STATS_EN
   logic [CNT_W-1:0] rd_cnt_q;
   logic [CNT_W-1:0] wr_cnt_q;
   logic [CNT_W-1:0] err_cnt_q;

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else if (state_q == ACCESS) begin
         if (!legal) begin
            if (~&err_cnt_q) err_cnt_q <= err_cnt_q + CNT_W'(1);
         end else if (is_read) begin
            if (~&rd_cnt_q) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
         end else begin
            if (~&wr_cnt_q) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
         end
      end
   end

   assign rd_cnt  = rd_cnt_q;
   assign wr_cnt  = wr_cnt_q;
   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states, one with none;
// table vectors, back-pressure, reset-abort and zero-wait sequences.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   localparam int W0 = 2;
   localparam int W1 = 0;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid [2];
   logic        req_ready [2];
   logic [31:0] req_addr  [2];
   logic [3:0]  req_we    [2];
   logic [31:0] req_wdata [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];
   dmem_state_e dbg_state [2];
`ifdef DMEM_RESPONDER_STATS_EN
   logic [15:0] rd_cnt  [2];
   logic [15:0] wr_cnt  [2];
   logic [15:0] err_cnt [2];
`endif

   logic [32:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_rd_exp [2];
   int          n_wr_exp [2];
   int          n_err_exp[2];
   vec_t        tbl0 [18];
   vec_t        tbl1 [4];
   logic [31:0] rnd  [6];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W0), .CNT_W(16)) u_dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
      .req_we(req_we[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0]),
`ifdef DMEM_RESPONDER_STATS_EN
      .rd_cnt(rd_cnt[0]), .wr_cnt(wr_cnt[0]), .err_cnt(err_cnt[0]),
`endif
      .dbg_state_o(dbg_state[0])
   );

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W1), .CNT_W(16)) u_dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
      .req_we(req_we[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1]),
`ifdef DMEM_RESPONDER_STATS_EN
      .rd_cnt(rd_cnt[1]), .wr_cnt(wr_cnt[1]), .err_cnt(err_cnt[1]),
`endif
      .dbg_state_o(dbg_state[1])
   );

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic vec_t mk(input logic [31:0] addr, input logic [3:0] we,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input logic err);
      vec_t v;
      v.addr  = addr;
      v.we    = we;
      v.wdata = wdata;
      v.rdata = rdata;
      v.err   = err;
      return v;
   endfunction

   function automatic int wait_of(input int d);
      return (d == 0) ? W0 : W1;
   endfunction

   // One transaction: wait for req_ready, present for one accept cycle, count
   // edges to rsp_valid, compare against the scoreboard, optionally stall rsp_ready.
   task automatic do_req(input int d, input vec_t v, input int hold);
      int          lat;
      logic [32:0] e;
      lat = 0;
      while (!req_ready[d] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("req_ready_before_d%0d", d), 64'(req_ready[d]), 64'(1));
      if (!req_ready[d]) return;
      exp_q.push_back({v.err, v.rdata});
      if (v.err) n_err_exp[d]++;
      else if (v.we == 4'b0000) n_rd_exp[d]++;
      else n_wr_exp[d]++;
      rsp_ready[d] = (hold == 0);
      req_valid[d] = 1'b1;
      req_addr[d]  = v.addr;
      req_we[d]    = v.we;
      req_wdata[d] = v.wdata;
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      req_addr[d]  = $urandom;
      req_we[d]    = 4'($urandom_range(0, 15));
      req_wdata[d] = $urandom;
      lat = 1;
      while (!rsp_valid[d] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("latency_d%0d_a%0h", d, v.addr), 64'(lat), 64'(wait_of(d) + 2));
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 64'(exp_q.size()), 64'(1));
         return;
      end
      e = exp_q.pop_front();
      if (!rsp_valid[d]) return;
      check($sformatf("rdata_d%0d_a%0h", d, v.addr), 64'(rsp_rdata[d]), 64'(e[31:0]));
      check($sformatf("err_d%0d_a%0h", d, v.addr), 64'(rsp_err[d]), 64'(e[32]));
      check($sformatf("req_ready_busy_d%0d", d), 64'(req_ready[d]), 64'(0));
      for (int i = 0; i < hold; i++) begin
         req_valid[d] = 1'b1;
         req_addr[d]  = 32'h10;
         req_we[d]    = 4'b0000;
         @(posedge clk); #1;
         check($sformatf("hold_valid_%0d", i), 64'(rsp_valid[d]), 64'(1));
         check($sformatf("hold_rdata_%0d", i), 64'(rsp_rdata[d]), 64'(e[31:0]));
         check($sformatf("hold_err_%0d", i), 64'(rsp_err[d]), 64'(e[32]));
         check($sformatf("hold_ready_%0d", i), 64'(req_ready[d]), 64'(0));
      end
      req_valid[d] = 1'b0;
      rsp_ready[d] = 1'b1;
      @(posedge clk); #1;
      check($sformatf("rsp_drop_d%0d", d), 64'(rsp_valid[d]), 64'(0));
   endtask

   task automatic zero_tallies();
      for (int d = 0; d < 2; d++) begin
         n_rd_exp[d]  = 0;
         n_wr_exp[d]  = 0;
         n_err_exp[d] = 0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0;
         req_addr[d]  = '0;
         req_we[d]    = '0;
         req_wdata[d] = '0;
         rsp_ready[d] = 1'b1;
      end
      zero_tallies();

      tbl0[0]  = mk(32'h10,   4'b1111, 32'hDEADBEEF, 32'h0,        1'b0);
      tbl0[1]  = mk(32'h10,   4'b0000, 32'h0,        32'hDEADBEEF, 1'b0);
      tbl0[2]  = mk(32'h11,   4'b0010, 32'h0000AA00, 32'h0,        1'b0);
      tbl0[3]  = mk(32'h10,   4'b0000, 32'h0,        32'hDEADAAEF, 1'b0);
      tbl0[4]  = mk(32'h13,   4'b1100, 32'h12340000, 32'h0,        1'b1);
      tbl0[5]  = mk(32'h10,   4'b0000, 32'h0,        32'hDEADAAEF, 1'b0);
      tbl0[6]  = mk(32'h1000, 4'b0000, 32'h0,        32'h0,        1'b1);
      tbl0[7]  = mk(32'h1000, 4'b1111, 32'h11111111, 32'h0,        1'b1);
      tbl0[8]  = mk(32'h12,   4'b1100, 32'h55550000, 32'h0,        1'b0);
      tbl0[9]  = mk(32'h13,   4'b0000, 32'h0,        32'h5555AAEF, 1'b0);
      tbl0[10] = mk(32'h14,   4'b1111, 32'h00000000, 32'h0,        1'b0);
      tbl0[11] = mk(32'h17,   4'b1000, 32'h77777777, 32'h0,        1'b0);
      tbl0[12] = mk(32'h15,   4'b0011, 32'h99999999, 32'h0,        1'b1);
      tbl0[13] = mk(32'h16,   4'b1111, 32'h99999999, 32'h0,        1'b1);
      tbl0[14] = mk(32'h14,   4'b0101, 32'h99999999, 32'h0,        1'b1);
      tbl0[15] = mk(32'h16,   4'b0000, 32'h0,        32'h77000000, 1'b0);
      tbl0[16] = mk(32'hFFC,  4'b1111, 32'hA5A55A5A, 32'h0,        1'b0);
      tbl0[17] = mk(32'hFFF,  4'b0000, 32'h0,        32'hA5A55A5A, 1'b0);

      tbl1[0]  = mk(32'h40,   4'b1111, 32'hCAFEF00D, 32'h0,        1'b0);
      tbl1[1]  = mk(32'h42,   4'b0000, 32'h0,        32'hCAFEF00D, 1'b0);
      tbl1[2]  = mk(32'h1000, 4'b0000, 32'h0,        32'h0,        1'b1);
      tbl1[3]  = mk(32'h41,   4'b0011, 32'h0000FFFF, 32'h0,        1'b1);

      repeat (2) @(posedge clk);
      #1;
      check("reset_req_ready", 64'(req_ready[0]), 64'(0));
      check("reset_rsp_valid", 64'(rsp_valid[0]), 64'(0));
      check("reset_rsp_rdata", 64'(rsp_rdata[0]), 64'(0));
      check("reset_rsp_err",   64'(rsp_err[0]),   64'(0));
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("release_req_ready_low", 64'(req_ready[0]), 64'(0));
      @(posedge clk); #1;
      check("release_req_ready_high", 64'(req_ready[0]), 64'(1));

      for (int i = 0; i < 18; i++) do_req(0, tbl0[i], 0);

      // Back-pressure: response held ten cycles with a competing request present.
      do_req(0, mk(32'h10, 4'b0000, 32'h0, 32'h5555AAEF, 1'b0), 10);
      do_req(0, mk(32'h1004, 4'b0000, 32'h0, 32'h0, 1'b1), 10);

      // Reset during the wait states of a write must leave storage untouched.
      do_req(0, mk(32'h20, 4'b1111, 32'h12345678, 32'h0, 1'b0), 0);
      req_valid[0] = 1'b1;
      req_addr[0]  = 32'h20;
      req_we[0]    = 4'b1111;
      req_wdata[0] = 32'hFFFFFFFF;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      check("abort_in_wait", 64'(dbg_state[0]), 64'(WAIT));
      #2;
      reset = 1'b0;
      #1;
      zero_tallies();
      check("abort_req_ready", 64'(req_ready[0]), 64'(0));
      check("abort_rsp_valid", 64'(rsp_valid[0]), 64'(0));
      check("abort_rsp_rdata", 64'(rsp_rdata[0]), 64'(0));
      check("abort_rsp_err",   64'(rsp_err[0]),   64'(0));
      check("abort_state",     64'(dbg_state[0]), 64'(IDLE));
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      do_req(0, mk(32'h20, 4'b0000, 32'h0, 32'h12345678, 1'b0), 0);

      for (int i = 0; i < 4; i++) do_req(1, tbl1[i], 0);
      for (int i = 0; i < 6; i++) begin
         rnd[i] = $urandom;
         do_req(1, mk(32'h100 + 32'(4 * i), 4'b1111, rnd[i], 32'h0, 1'b0), 0);
      end
      for (int i = 0; i < 6; i++)
         do_req(1, mk(32'h100 + 32'(4 * i) + 32'($urandom_range(0, 3)), 4'b0000,
                      $urandom, rnd[i], 1'b0), 0);
      do_req(1, mk(32'h40, 4'b0000, 32'h0, 32'hCAFEF00D, 1'b0), 3);

`ifdef DMEM_RESPONDER_STATS_EN
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rd_cnt_d%0d", d),  64'(rd_cnt[d]),  64'(n_rd_exp[d]));
         check($sformatf("wr_cnt_d%0d", d),  64'(wr_cnt[d]),  64'(n_wr_exp[d]));
         check($sformatf("err_cnt_d%0d", d), 64'(err_cnt[d]), 64'(n_err_exp[d]));
      end
`endif
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
